fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters: XLEN, 32, datapath width; REGADDR_WIDTH, 4, register-address width; RESET_PC, 0, first fetch address; NOP_INSTR, 32'h00000013, bubble encoding.
REQ-002 Ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset; one clock, no other clock domain.
REQ-003 pc_write in 1, PC update enable from the hazard unit; if_id_write in 1, IF/ID load enable from the hazard unit.
REQ-004 branch_taken in 1, redirect request from EX; branch_target in XLEN, redirect address.
REQ-005 imem_req_valid out 1, imem_req_addr out XLEN, imem_req_ready in 1: request handshake.
REQ-006 imem_rsp_valid in 1, imem_rsp_data in 32: response; one response per accepted request, in order.
REQ-007 if_id_valid out 1, if_id_pc out XLEN, if_id_instr out 32: IF/ID register.
REQ-008 if_id_rs out REGADDR_WIDTH = if_id_instr[15 +: REGADDR_WIDTH]; if_id_rt out REGADDR_WIDTH = if_id_instr[20 +: REGADDR_WIDTH]; both combinational, fed back to the hazard unit.

Function
REQ-009 FSM states: FETCH, WAIT, HOLD; at most one outstanding memory request.
REQ-010 FETCH: imem_req_valid=1, imem_req_addr=pc; go to WAIT when imem_req_ready=1, otherwise stay.
REQ-011 imem_req_valid SHALL be 0 in WAIT and HOLD.
REQ-012 WAIT, imem_rsp_valid=1, kill=0, advance=1: load IF/ID {valid=1, pc, data}, pc<=pc+4, go to FETCH.
REQ-013 advance = pc_write AND if_id_write.
REQ-014 WAIT, imem_rsp_valid=1, kill=0, advance=0: capture the response in a one-entry skid (pc, data), leave IF/ID unchanged, go to HOLD.
REQ-015 HOLD: when advance=1, load IF/ID from the skid, pc<=pc+4, go to FETCH; otherwise hold everything.
REQ-016 If advance=1 and no instruction is loaded in that cycle, if_id_valid<=0 and if_id_instr<=NOP_INSTR (bubble).
REQ-017 If advance=0, the IF/ID register SHALL hold its value, including if_id_valid.
REQ-018 branch_taken=1 overrides all other inputs, including advance=0: pc<=branch_target, if_id_valid<=0, if_id_instr<=NOP_INSTR, skid discarded.
REQ-019 Branch in FETCH or HOLD: next state FETCH. Branch in FETCH on a cycle where imem_req_ready=1: set kill and go to WAIT, because the old address was accepted.
REQ-020 Branch in WAIT without imem_rsp_valid: set kill, stay in WAIT.
REQ-021 Branch in WAIT with imem_rsp_valid: drop the response, go to FETCH.
REQ-022 WAIT with kill=1: the response is discarded, kill is cleared, and the state goes to FETCH at the current pc (the branch target).
REQ-023 PC arithmetic is modulo 2^XLEN; 32'hFFFFFFFC+4 wraps to 0.
REQ-024 Latency: a response on cycle N with advance=1 is visible on the IF/ID outputs at cycle N+1.

Reset
REQ-025 rst asserted asynchronously forces: state=FETCH, pc=RESET_PC, kill=0, skid empty, if_id_valid=0, if_id_pc=0, if_id_instr=NOP_INSTR.
REQ-026 Any response arriving during reset or in the first cycle after it is ignored.
REQ-027 The first request, imem_req_addr=RESET_PC, is presented in the first cycle after rst deasserts.
REQ-028 Reset mid-transaction abandons the outstanding request; the memory side is reset concurrently.

Structure
REQ-029 Shared package holds: XLEN, NOP_INSTR, the RISC-V rs1/rs2 field offsets (15, 20), and the state enum {FETCH, WAIT, HOLD}.
REQ-030 One sub-module, if_id_reg: the pipeline register with load, flush and asynchronous reset.
REQ-031 The FSM, pc and skid stay in fetch_stage.

Verification
REQ-032 Reset release, imem_req_ready=1, each response returned 1 cycle after its request, advance=1 -> if_id_pc sequence 0,4,8,12 with if_id_valid=1, one instruction every 2 cycles.
REQ-033 Stall: pc_write=if_id_write=0 for 3 cycles while a response (32'h00A00093) arrives -> IF/ID held, response kept in HOLD; on release the instruction appears next cycle with its correct pc, and no instruction is lost or duplicated.
REQ-034 Branch to 0x100 while in WAIT, response arriving 2 cycles later -> that response is discarded, next request address is 0x100, if_id_valid=0 until the 0x100 instruction loads.
REQ-035 branch_taken and imem_rsp_valid in the same cycle with if_id_write=0 -> flush wins: if_id_valid=0, pc=branch_target, no HOLD entry.
REQ-036 RESET_PC=32'hFFFFFFFC -> second request address is 0; rst asserted mid-WAIT -> outputs reach their reset values without a clock edge.
REQ-037 Load-use check: if_id_instr with rs1=5, hazard unit stalling one cycle -> if_id_rs=5 stable across the stall.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants and FSM state type for the instruction fetch stage.
package fetch_stage_pkg;

  localparam int unsigned XLEN       = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int unsigned RS1_OFFSET = 15;
  localparam int unsigned RS2_OFFSET = 20;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD
  } state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, bubble on empty advance, flush, async reset.
module if_id_reg #(
  parameter int unsigned XLEN      = fetch_stage_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);
  import fetch_stage_pkg::*;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (en) begin
      if (load) begin
        valid <= 1'b1;
        pc    <= load_pc;
        instr <= load_instr;
      end else begin
        // Advancing with nothing to hand over inserts a bubble.
        valid <= 1'b0;
        instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding imem request FSM, PC, one-entry skid and IF/ID register.
module fetch_stage #(
  parameter int unsigned      XLEN          = fetch_stage_pkg::XLEN,
  parameter int unsigned      REGADDR_WIDTH = 4,
  parameter logic [XLEN-1:0]  RESET_PC      = '0,
  parameter logic [31:0]      NOP_INSTR     = fetch_stage_pkg::NOP_INSTR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pc_write,
  input  logic                     if_id_write,
  input  logic                     branch_taken,
  input  logic [XLEN-1:0]          branch_target,
  output logic                     imem_req_valid,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_req_ready,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  output logic                     if_id_valid,
  output logic [XLEN-1:0]          if_id_pc,
  output logic [31:0]              if_id_instr,
  output logic [REGADDR_WIDTH-1:0] if_id_rs,
  output logic [REGADDR_WIDTH-1:0] if_id_rt
);
  import fetch_stage_pkg::*;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic            kill_q, kill_d;
  logic            advance, load;
  logic [XLEN-1:0] load_pc;
  logic [31:0]     load_instr;

  assign advance = pc_write & if_id_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    load         = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (branch_taken) begin
          pc_d   = branch_target;
          // The old address is accepted this cycle, so its response must be dropped.
          kill_d = imem_req_ready;
        end
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (branch_taken) begin
          pc_d   = branch_target;
          kill_d = ~imem_rsp_valid;
          if (imem_rsp_valid) state_d = FETCH;
        end else if (imem_rsp_valid) begin
          state_d = FETCH;
          if (kill_q) begin
            kill_d = 1'b0;
          end else if (advance) begin
            load = 1'b1;
            pc_d = pc_q + XLEN'(4);
          end else begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem_rsp_data;
            state_d      = HOLD;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = FETCH;
        end else if (advance) begin
          load    = 1'b1;
          pc_d    = pc_q + XLEN'(4);
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req_valid = (state_q == FETCH);
    imem_req_addr  = pc_q;
    load_pc        = (state_q == HOLD) ? skid_pc_q : pc_q;
    load_instr     = (state_q == HOLD) ? skid_instr_q : imem_rsp_data;
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .en         (advance),
    .load       (load),
    .flush      (branch_taken),
    .load_pc    (load_pc),
    .load_instr (load_instr),
    .valid      (if_id_valid),
    .pc         (if_id_pc),
    .instr      (if_id_instr)
  );

  assign if_id_rs = if_id_instr[RS1_OFFSET +: REGADDR_WIDTH];
  assign if_id_rt = if_id_instr[RS2_OFFSET +: REGADDR_WIDTH];

endmodule

// File: tb/tb_fetch_stage.sv
// Cycle-vector bench for fetch_stage with an IF/ID load scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
  localparam logic [31:0] Z    = 32'h0;
  localparam logic [31:0] I0   = 32'h0010_0093;
  localparam logic [31:0] I4   = 32'h0002_8093;  // rs1 = x5
  localparam logic [31:0] I8   = 32'h0030_0113;
  localparam logic [31:0] I12  = 32'h0040_0193;
  localparam logic [31:0] S    = 32'h00A0_0093;
  localparam logic [31:0] B0   = 32'h0050_0213;
  localparam logic [31:0] C0   = 32'h0060_0293;
  localparam logic [31:0] E0   = 32'h0070_0313;
  localparam logic [31:0] H0   = 32'h0080_0393;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pc_write = 1'b0, if_id_write = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;

  logic        req_valid, if_id_valid, d2_req_valid, d2_if_id_valid;
  logic [31:0] req_addr, if_id_pc, if_id_instr, d2_req_addr, d2_if_id_pc, d2_if_id_instr;
  logic [3:0]  if_id_rs, if_id_rt, d2_if_id_rs, d2_if_id_rt;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_write(if_id_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_write(if_id_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req_valid(d2_req_valid), .imem_req_addr(d2_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_id_valid(d2_if_id_valid), .if_id_pc(d2_if_id_pc), .if_id_instr(d2_if_id_instr),
    .if_id_rs(d2_if_id_rs), .if_id_rt(d2_if_id_rt)
  );

  typedef struct {
    logic        rst, pw, iw, br;
    logic [31:0] tgt;
    logic        rdy, rv, push;
    logic [31:0] rd;
    logic        ereqv, ev;
    logic [31:0] eaddr, epc, einstr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic pend = 1'b0;

  // ctl = {rst, pc_write, if_id_write, branch}; mem = {ready, rsp_valid, push}; ex = {req_valid, valid}
  function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] tgt, input logic [2:0] mem,
                              input logic [31:0] rd, input logic [1:0] ex,
                              input logic [31:0] eaddr, input logic [31:0] epc,
                              input logic [31:0] einstr);
    vec_t v;
    v.rst = ctl[3]; v.pw = ctl[2]; v.iw = ctl[1]; v.br = ctl[0]; v.tgt = tgt;
    v.rdy = mem[2]; v.rv = mem[1]; v.push = mem[0]; v.rd = rd;
    v.ereqv = ex[1]; v.ev = ex[0]; v.eaddr = eaddr; v.epc = epc; v.einstr = einstr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    if (pend && if_id_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_sb got=load pc=%h want=no_load", tag, if_id_pc);
      end else begin
        e = sb.pop_front();
        chk({tag, "_sb_pc"}, if_id_pc, e.pc);
        chk({tag, "_sb_instr"}, if_id_instr, e.instr);
      end
    end
    rst = v.rst; pc_write = v.pw; if_id_write = v.iw; branch_taken = v.br;
    branch_target = v.tgt; imem_req_ready = v.rdy; imem_rsp_valid = v.rv; imem_rsp_data = v.rd;
    if (v.push) sb.push_back('{pc: v.eaddr, instr: v.rd});
    #1;
    chk({tag, "_req_valid"}, 32'(req_valid), 32'(v.ereqv));
    chk({tag, "_req_addr"}, req_addr, v.eaddr);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'(v.ev));
    chk({tag, "_instr"}, if_id_instr, v.einstr);
    chk({tag, "_rs"}, 32'(if_id_rs), 32'(v.einstr[18:15]));
    chk({tag, "_rt"}, 32'(if_id_rt), 32'(v.einstr[23:20]));
    if (v.ev || v.rst) chk({tag, "_pc"}, if_id_pc, v.epc);
    pend = v.pw & v.iw & ~v.br & ~v.rst;
  endtask

  initial begin
    // Reset, response ignored right after reset, steady stream 0,4,8,12 with a one-cycle stall.
    tbl.push_back(mk(4'b1110, Z,     3'b110, JUNK, 2'b10, 32'h0,   Z,       NOP));
    tbl.push_back(mk(4'b0110, Z,     3'b110, JUNK, 2'b10, 32'h0,   Z,       NOP));
    tbl.push_back(mk(4'b0110, Z,     3'b111, I0,   2'b00, 32'h0,   Z,       NOP));
    tbl.push_back(mk(4'b0110, Z,     3'b100, Z,    2'b11, 32'h4,   32'h0,   I0));
    tbl.push_back(mk(4'b0110, Z,     3'b111, I4,   2'b00, 32'h4,   Z,       NOP));
    tbl.push_back(mk(4'b0000, Z,     3'b100, Z,    2'b11, 32'h8,   32'h4,   I4));
    tbl.push_back(mk(4'b0110, Z,     3'b111, I8,   2'b01, 32'h8,   32'h4,   I4));
    tbl.push_back(mk(4'b0110, Z,     3'b100, Z,    2'b11, 32'hC,   32'h8,   I8));
    tbl.push_back(mk(4'b0110, Z,     3'b111, I12,  2'b00, 32'hC,   Z,       NOP));
    // Stall while a response arrives: held in HOLD, released later.
    tbl.push_back(mk(4'b0000, Z,     3'b100, Z,    2'b11, 32'h10,  32'hC,   I12));
    tbl.push_back(mk(4'b0000, Z,     3'b111, S,    2'b01, 32'h10,  32'hC,   I12));
    tbl.push_back(mk(4'b0000, Z,     3'b100, Z,    2'b01, 32'h10,  32'hC,   I12));
    tbl.push_back(mk(4'b0000, Z,     3'b100, Z,    2'b01, 32'h10,  32'hC,   I12));
    tbl.push_back(mk(4'b0110, Z,     3'b100, Z,    2'b01, 32'h10,  32'hC,   I12));
    tbl.push_back(mk(4'b0110, Z,     3'b100, Z,    2'b11, 32'h14,  32'h10,  S));
    // Branch in WAIT, stale response two cycles later is dropped.
    tbl.push_back(mk(4'b0111, 32'h100, 3'b100, Z,  2'b00, 32'h14,  Z,       NOP));
    tbl.push_back(mk(4'b0110, Z,     3'b100, Z,    2'b00, 32'h100, Z,       NOP));
    tbl.push_back(mk(4'b0110, Z,     3'b110, JUNK, 2'b00, 32'h100, Z,       NOP));
    tbl.push_back(mk(4'b0110, Z,     3'b100, Z,    2'b10, 32'h100, Z,       NOP));
    tbl.push_back(mk(4'b0110, Z,     3'b111, B0,   2'b00, 32'h100, Z,       NOP));
    // Branch and response together with if_id_write low: flush wins, no HOLD.
    tbl.push_back(mk(4'b0000, Z,     3'b100, Z,    2'b11, 32'h104, 32'h100, B0));
    tbl.push_back(mk(4'b0101, 32'h200, 3'b110, JUNK, 2'b01, 32'h104, 32'h100, B0));
    tbl.push_back(mk(4'b0100, Z,     3'b100, Z,    2'b10, 32'h200, Z,       NOP));
    tbl.push_back(mk(4'b0110, Z,     3'b111, C0,   2'b00, 32'h200, Z,       NOP));
    // Branch in FETCH while the old request is accepted: kill its response.
    tbl.push_back(mk(4'b0111, 32'h300, 3'b100, Z,  2'b11, 32'h204, 32'h200, C0));
    tbl.push_back(mk(4'b0110, Z,     3'b110, JUNK, 2'b00, 32'h300, Z,       NOP));
    tbl.push_back(mk(4'b0110, Z,     3'b100, Z,    2'b10, 32'h300, Z,       NOP));
    tbl.push_back(mk(4'b0110, Z,     3'b111, E0,   2'b00, 32'h300, Z,       NOP));
    tbl.push_back(mk(4'b0110, Z,     3'b000, Z,    2'b11, 32'h304, 32'h300, E0));
    tbl.push_back(mk(4'b0110, Z,     3'b000, Z,    2'b10, 32'h304, Z,       NOP));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("r%0d", i));

    // PC wrap on the second instance, then asynchronous reset in the middle of WAIT.
    step(mk(4'b1110, Z, 3'b100, Z, 2'b10, 32'h0, Z, NOP), "h0");
    chk("h0_d2_addr", d2_req_addr, 32'hFFFF_FFFC);
    chk("h0_d2_req_valid", 32'(d2_req_valid), 32'd1);
    chk("h0_d2_valid", 32'(d2_if_id_valid), 32'd0);
    chk("h0_d2_pc", d2_if_id_pc, 32'h0);
    chk("h0_d2_instr", d2_if_id_instr, NOP);
    chk("h0_d2_rsrt", 32'({d2_if_id_rs, d2_if_id_rt}), 32'h0);
    step(mk(4'b0110, Z, 3'b100, Z, 2'b10, 32'h0, Z, NOP), "h1");
    chk("h1_d2_addr", d2_req_addr, 32'hFFFF_FFFC);
    step(mk(4'b0110, Z, 3'b111, H0, 2'b00, 32'h0, Z, NOP), "h2");
    chk("h2_d2_req_valid", 32'(d2_req_valid), 32'd0);
    step(mk(4'b0000, Z, 3'b100, Z, 2'b11, 32'h4, 32'h0, H0), "h3");
    chk("h3_d2_wrap_addr", d2_req_addr, 32'h0);
    chk("h3_d2_req_valid", 32'(d2_req_valid), 32'd1);
    chk("h3_d2_pc", d2_if_id_pc, 32'hFFFF_FFFC);
    step(mk(4'b0000, Z, 3'b100, Z, 2'b01, 32'h4, 32'h0, H0), "h4");
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(if_id_valid), 32'd0);
    chk("async_rst_instr", if_id_instr, NOP);
    chk("async_rst_pc", if_id_pc, 32'h0);
    chk("async_rst_req_valid", 32'(req_valid), 32'd1);
    chk("async_rst_addr", req_addr, 32'h0);
    chk("async_rst_d2_addr", d2_req_addr, 32'hFFFF_FFFC);
    step(mk(4'b1000, Z, 3'b110, JUNK, 2'b10, 32'h0, Z, NOP), "h5");
    step(mk(4'b0110, Z, 3'b100, Z, 2'b10, 32'h0, Z, NOP), "h6");

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
